// File: rtl/scan_slot_responder.sv
// Responder end of one tiny-design scan-chain slot: oversamples the chain lines,
// shifts/loads a local register per scan-clock rise and forwards the chain retimed.
module scan_slot_responder #(
    parameter int unsigned NUM_IOS     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_clk_in,
    input  logic               scan_data_in,
    input  logic               scan_select,
    input  logic               scan_latch_en,
    input  logic [NUM_IOS-1:0] design_out,
    input  logic               err_clr,
    output logic               scan_clk_out,
    output logic               scan_data_out,
    output logic               scan_select_out,
    output logic               scan_latch_en_out,
    output logic [NUM_IOS-1:0] design_in,
    output logic               frame_err,
    output logic [CNT_W-1:0]   latch_cnt
);

    localparam int unsigned BIT_W  = (NUM_IOS > 2) ? $clog2(NUM_IOS) : 1;
    localparam int unsigned ARM_N  = SYNC_STAGES + 1;
    localparam int unsigned ARM_W  = $clog2(ARM_N + 1);
    localparam int unsigned LN_CLK = 0;
    localparam int unsigned LN_DAT = 1;
    localparam int unsigned LN_SEL = 2;
    localparam int unsigned LN_LAT = 3;

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  w_lines;
    logic [3:0]                  w_sync;
    logic                        r_hist_clk;
    logic                        r_hist_sel;
    logic                        r_hist_lat;
    logic [ARM_W-1:0]            r_arm_cnt;
    logic                        w_armed;
    logic                        w_clk_rise;
    logic                        w_clk_fall;
    logic                        w_latch_rise;

    logic [NUM_IOS-1:0]          r_shift;
    logic [NUM_IOS-1:0]          r_design_in;
    logic [BIT_W-1:0]            r_bit_cnt;
    logic                        r_data_out;
    logic                        r_frame_err;
    logic [CNT_W-1:0]            r_latch_cnt;

    logic [NUM_IOS-1:0]          w_shift_nxt;
    logic [NUM_IOS-1:0]          w_design_in_nxt;
    logic [BIT_W-1:0]            w_bit_cnt_nxt;
    logic                        w_data_out_nxt;
    logic                        w_frame_err_nxt;
    logic [CNT_W-1:0]            w_latch_cnt_nxt;

    assign w_lines = {scan_latch_en, scan_select, scan_data_in, scan_clk_in};
    assign w_sync  = r_sync[SYNC_STAGES-1];

    // Synchronizer chain, edge history and post-reset arming window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= '0;
            r_hist_clk <= 1'b0;
            r_hist_sel <= 1'b0;
            r_hist_lat <= 1'b0;
            r_arm_cnt  <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], w_lines};
            r_hist_clk <= w_sync[LN_CLK];
            r_hist_sel <= w_sync[LN_SEL];
            r_hist_lat <= w_sync[LN_LAT];
            if (r_arm_cnt != ARM_W'(ARM_N)) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end
        end
    end

    assign w_armed      = (r_arm_cnt == ARM_W'(ARM_N));
    assign w_clk_rise   = w_armed &  w_sync[LN_CLK] & ~r_hist_clk;
    assign w_clk_fall   = w_armed & ~w_sync[LN_CLK] &  r_hist_clk;
    assign w_latch_rise = w_armed &  w_sync[LN_LAT] & ~r_hist_lat;

    // Next-state for the slot datapath; latch always sees the pre-shift register.
    always_comb begin
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_data_out_nxt  = r_data_out;
        w_design_in_nxt = r_design_in;
        w_frame_err_nxt = r_frame_err;
        w_latch_cnt_nxt = r_latch_cnt;

        if (w_clk_rise) begin
            if (w_sync[LN_SEL]) begin
                w_shift_nxt   = design_out;
                w_bit_cnt_nxt = '0;
            end else begin
                w_shift_nxt   = {r_shift[NUM_IOS-2:0], w_sync[LN_DAT]};
                w_bit_cnt_nxt = (r_bit_cnt == BIT_W'(NUM_IOS - 1)) ? '0
                                                                    : r_bit_cnt + BIT_W'(1);
            end
        end

        if (w_clk_fall) begin
            w_data_out_nxt = r_shift[NUM_IOS-1];
        end

        if (err_clr) begin
            w_frame_err_nxt = 1'b0;
        end

        if (w_latch_rise) begin
            w_design_in_nxt = r_shift;
            w_latch_cnt_nxt = r_latch_cnt + CNT_W'(1);
            if (r_bit_cnt != '0) begin
                w_frame_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_data_out  <= 1'b0;
            r_design_in <= '0;
            r_frame_err <= 1'b0;
            r_latch_cnt <= '0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_data_out  <= w_data_out_nxt;
            r_design_in <= w_design_in_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_latch_cnt <= w_latch_cnt_nxt;
        end
    end

    assign scan_clk_out      = r_hist_clk;
    assign scan_select_out   = r_hist_sel;
    assign scan_latch_en_out = r_hist_lat;
    assign scan_data_out     = r_data_out;
    assign design_in         = r_design_in;
    assign frame_err         = r_frame_err;
    assign latch_cnt         = r_latch_cnt;

endmodule

// File: tb/tb_scan_slot_responder.sv
// Two chained scan slots driven at scan-transaction level against a chain-register model.
module tb_scan_slot_responder;

    localparam logic [7:0] FAR_DOUT = 8'h5A;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_clk_in = 1'b0;
    logic       scan_data_in = 1'b0;
    logic       scan_select = 1'b0;
    logic       scan_latch_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] near_dout = 8'h00;

    logic       c_clk, c_data, c_sel, c_lat;
    logic [7:0] near_din;
    logic       near_err;
    logic [15:0] near_cnt;
    logic       f_clk, f_data, f_sel, f_lat;
    logic [7:0] far_din;
    logic       far_err;
    logic [15:0] far_cnt;

    scan_slot_responder u_near (
        .clk(clk), .reset_n(reset_n),
        .scan_clk_in(scan_clk_in), .scan_data_in(scan_data_in),
        .scan_select(scan_select), .scan_latch_en(scan_latch_en),
        .design_out(near_dout), .err_clr(err_clr),
        .scan_clk_out(c_clk), .scan_data_out(c_data),
        .scan_select_out(c_sel), .scan_latch_en_out(c_lat),
        .design_in(near_din), .frame_err(near_err), .latch_cnt(near_cnt)
    );

    scan_slot_responder u_far (
        .clk(clk), .reset_n(reset_n),
        .scan_clk_in(c_clk), .scan_data_in(c_data),
        .scan_select(c_sel), .scan_latch_en(c_lat),
        .design_out(FAR_DOUT), .err_clr(err_clr),
        .scan_clk_out(f_clk), .scan_data_out(f_data),
        .scan_select_out(f_sel), .scan_latch_en_out(f_lat),
        .design_in(far_din), .frame_err(far_err), .latch_cnt(far_cnt)
    );

    always #5 clk = ~clk;

    // Model: the two slots behave as one 16-bit chain register {far, near}.
    logic [15:0] m_chain;
    int          m_bitcnt;
    logic [7:0]  m_near_in, m_far_in;
    logic        m_err;
    int          m_lcnt;

    int   errors = 0;
    int   checks = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_chain   = '0;
        m_bitcnt  = 0;
        m_near_in = '0;
        m_far_in  = '0;
        m_err     = 1'b0;
        m_lcnt    = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            chk("near_design_in", 32'(near_din), 32'(m_near_in));
            chk("far_design_in", 32'(far_din), 32'(m_far_in));
            chk("frame_err", 32'(near_err), 32'(m_err));
            chk("latch_cnt", 32'(near_cnt), 32'(m_lcnt));
        end
    end

    task automatic do_reset(input logic clk_level);
        cmp_en        = 1'b0;
        reset_n       = 1'b0;
        scan_clk_in   = clk_level;
        scan_data_in  = 1'b0;
        scan_select   = 1'b0;
        scan_latch_en = 1'b0;
        err_clr       = 1'b0;
        tick(3);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One scan-clock pulse; returns scan_data_out seen at the forwarded clock rise.
    task automatic pulse(input logic sel, input logic b, output logic seen_bit);
        logic seen;
        logic exp_do;
        cmp_en       = 1'b0;
        scan_select  = sel;
        scan_data_in = b;
        tick(8);
        exp_do      = m_chain[7];
        seen        = 1'b0;
        seen_bit    = 1'bx;
        scan_clk_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (!seen && c_clk) begin
                seen     = 1'b1;
                seen_bit = c_data;
                chk("scan_data_out_at_rise", 32'(c_data), 32'(exp_do));
            end
        end
        if (!seen) chk("scan_clk_out_rise_timeout", 32'(c_clk), 32'd1);
        scan_clk_in = 1'b0;
        tick(8);
        if (sel) begin
            m_chain  = {FAR_DOUT, near_dout};
            m_bitcnt = 0;
        end else begin
            m_chain  = {m_chain[14:0], b};
            m_bitcnt = (m_bitcnt + 1) % 8;
        end
        cmp_en = 1'b1;
        tick(2);
    endtask

    task automatic shift_byte(input logic [7:0] v);
        logic d;
        for (int i = 7; i >= 0; i--) pulse(1'b0, v[i], d);
    endtask

    // Latch pulse; optionally holds err_clr on exactly the cycle the latch edge acts.
    task automatic latch(input logic clr);
        cmp_en        = 1'b0;
        scan_latch_en = 1'b1;
        tick(2);
        err_clr = clr;
        tick(1);
        err_clr = 1'b0;
        tick(5);
        scan_latch_en = 1'b0;
        tick(8);
        m_near_in = m_chain[7:0];
        m_far_in  = m_chain[15:8];
        if (m_bitcnt != 0) m_err = 1'b1;
        else if (clr)      m_err = 1'b0;
        m_lcnt++;
        cmp_en = 1'b1;
        tick(2);
    endtask

    task automatic clear_err();
        cmp_en  = 1'b0;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err   = 1'b0;
        cmp_en  = 1'b1;
        tick(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       d;
        logic [7:0] seq;
        logic [7:0] exp_seq;
        logic [4:0] five;

        model_reset();

        // Scan clock held high across reset release: no spurious edge.
        do_reset(1'b1);
        tick(2);
        chk("clk_out_before_latency", 32'(c_clk), 32'd0);
        tick(1);
        chk("clk_out_after_latency", 32'(c_clk), 32'd1);
        tick(10);
        chk("idle_latch_cnt", 32'(near_cnt), 32'd0);
        chk("idle_data_out", 32'(c_data), 32'd0);
        cmp_en = 1'b1;
        tick(2);
        latch(1'b0);
        chk("no_spurious_shift_err", 32'(near_err), 32'd0);

        // Plain 8-bit frame.
        do_reset(1'b0);
        tick(6);
        shift_byte(8'hA5);
        latch(1'b0);
        chk("a5_design_in", 32'(near_din), 32'hA5);
        chk("a5_latch_cnt", 32'(near_cnt), 32'd1);
        chk("a5_frame_err", 32'(near_err), 32'd0);

        // Load design_out then shift it out.
        near_dout = 8'h3C;
        pulse(1'b1, 1'b0, d);
        exp_seq = 8'b0011_1100;
        for (int i = 7; i >= 0; i--) begin
            pulse(1'b0, 1'b0, d);
            seq[i] = d;
            chk("load_shift_seq_bit", 32'(d), 32'(exp_seq[i]));
        end
        chk("load_shift_seq", 32'(seq), 32'h3C);
        latch(1'b0);
        chk("far_after_load", 32'(far_din), 32'h3C);

        // Two-slot chain, 16 bits.
        shift_byte(8'h12);
        shift_byte(8'h34);
        latch(1'b0);
        chk("chain_far", 32'(far_din), 32'h12);
        chk("chain_near", 32'(near_din), 32'h34);
        chk("chain_latch_cnt", 32'(near_cnt), 32'd3);

        // Partial frames and error clear priority.
        five = 5'b10110;
        for (int i = 4; i >= 0; i--) pulse(1'b0, five[i], d);
        latch(1'b0);
        chk("partial_err_set", 32'(near_err), 32'd1);
        clear_err();
        chk("err_cleared", 32'(near_err), 32'd0);
        latch(1'b1);
        chk("set_wins_over_clr", 32'(near_err), 32'd1);

        // Reset in the middle of a frame.
        shift_byte(8'hFF);
        latch(1'b0);
        chk("ff_design_in", 32'(near_din), 32'hFF);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, d);
        cmp_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_design_in", 32'(near_din), 32'h00);
        chk("async_reset_far_in", 32'(far_din), 32'h00);
        chk("async_reset_cnt", 32'(near_cnt), 32'd0);
        chk("async_reset_err", 32'(near_err), 32'd0);
        tick(3);
        reset_n = 1'b1;
        model_reset();
        tick(6);
        shift_byte(8'h96);
        latch(1'b0);
        chk("post_reset_design_in", 32'(near_din), 32'h96);
        chk("post_reset_cnt", 32'(near_cnt), 32'd1);
        chk("post_reset_err", 32'(near_err), 32'd0);

        cmp_en = 1'b0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_slot_responder.md
Name: scan_slot_responder

Overview:
- Clock-synchronous model of one design slot on the tiny-design scan chain. It is the responder end of the chain driven by the scan controller.
- Oversamples the incoming scan clock, data, select and latch lines on the system clock, and shifts or loads a local register on each scan-clock rising edge.
- Presents latched inputs to the attached design.
- Forwards the chain to the next slot with lockup-style retiming.
- Used for FPGA prototyping and as a bench-side chain terminator.

Parameters:
- NUM_IOS, 8, width of design input/output buses and of the slot shift register.
- SYNC_STAGES, 2, synchronizer depth on the four chain inputs (minimum 2).
- CNT_W, 16, width of the latch event counter.

Ports:
- clk  input  1  system clock; must be at least 4x the scan clock toggle rate.
- reset_n  input  1  asynchronous active-low reset.
- scan_clk_in  input  1  chain clock from upstream (asynchronous).
- scan_data_in  input  1  chain data from upstream.
- scan_select  input  1  1 = a scan-clock rise loads design_out; 0 = it shifts.
- scan_latch_en  input  1  rising edge copies the shift register to design_in.
- design_out  input  NUM_IOS  outputs of the attached design.
- err_clr  input  1  synchronous clear of frame_err.
- scan_clk_out  output  1  retimed chain clock to downstream.
- scan_data_out  output  1  retimed chain data to downstream.
- scan_select_out  output  1  retimed select to downstream.
- scan_latch_en_out  output  1  retimed latch enable to downstream.
- design_in  output  NUM_IOS  latched inputs to the attached design.
- frame_err  output  1  sticky: a latch occurred with a partial frame shifted.
- latch_cnt  output  CNT_W  number of latch events since reset; wraps.

Behaviour:
- Reset (async assert, sync deassert effect): all synchronizers, edge-detect history, shift_reg, design_in, scan_*_out, frame_err, latch_cnt, bit_cnt = 0.
- Arm counter: edge detection is suppressed for SYNC_STAGES+1 cycles after reset release, so a high scan_clk_in at release produces no spurious edge.
- Synchronizers: each chain input passes through SYNC_STAGES flops. One history flop per line feeds edge detect.
- Detection latency: clk_rise, clk_fall and latch_rise pulse SYNC_STAGES+1 cycles after the input change, one cycle wide.
- Forwarded lines: scan_clk_out, scan_select_out and scan_latch_en_out equal the history-flop values. Their delay is therefore identical to detection latency.
- On clk_rise with select_sync=1: shift_reg <= design_out (sampled that cycle); bit_cnt <= 0.
- On clk_rise with select_sync=0: shift_reg <= {shift_reg[NUM_IOS-2:0], data_sync}; bit_cnt <= (bit_cnt==NUM_IOS-1) ? 0 : bit_cnt+1.
- scan_data_out updates to shift_reg[NUM_IOS-1] only on clk_fall. It is stable across the next scan_clk_out rise, so downstream captures exactly one bit per upstream rising edge.
- On latch_rise: design_in <= shift_reg (value before any same-cycle shift); latch_cnt <= latch_cnt+1, wrapping at 2^CNT_W.
- frame_err <= 1 on latch_rise if bit_cnt != 0.
- err_clr clears frame_err; a same-cycle set wins over clear.
- Simultaneous clk_rise and latch_rise: latch takes the pre-shift value and the shift still happens.
- Simultaneous select change and clk_rise: the synchronized select value of that cycle decides load vs shift.
- Reset mid-frame: all state is lost, and design_in returns to 0 immediately on assertion.
- No combinational path from any input to any output.

Test Plan:
- Reset with scan_clk_in=1 held, release, hold 10 cycles -> no shift occurs; shift_reg=0, scan_clk_out=1 after 3 cycles, latch_cnt=0.
- Shift 8 bits 0xA5 (MSB first, 8 clk per scan-clock phase), then pulse scan_latch_en -> design_in=0xA5, latch_cnt=1, frame_err=0.
- design_out=0x3C, scan_select=1, one scan-clock pulse, select=0, 8 pulses -> scan_data_out sequence 0,0,1,1,1,1,0,0 sampled on scan_clk_out rises.
- Chain two instances and shift 16 bits 0x12_34, then latch -> far slot design_in=0x12, near slot design_in=0x34.
- Shift 5 bits then latch -> frame_err=1. Assert err_clr -> 0. Assert err_clr together with another partial latch -> remains 1.
- Apply reset_n low while design_in=0xFF mid-shift -> design_in=0 the same cycle; 8 pulses plus latch after release yields the correct new value.
